// File: rtl/popcount_window_acc.sv
// Window accumulator for 5-bit popcounts: sums up to WINDOW accepted counts
// and presents sum, word count and threshold match on a held output handshake.
module popcount_window_acc #(
  parameter int WINDOW = 8,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       count_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             last_in,
  input  logic [ACC_W-1:0] threshold,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] words_out,
  output logic             match_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_out
);

  // state | meaning
  // ACCUM | accepting words, adding clamped counts into acc
  // HOLD  | result presented on out_valid, waiting for out_ready

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_add, sum_nxt;
  logic [CNT_W-1:0] idx, idx_nxt, words_nxt;
  logic [4:0]       c;
  logic             accept, closing, illegal;
  logic             match_nxt, err_nxt;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_comb begin
    illegal   = (count_in > 5'd16);
    c         = illegal ? 5'd16 : count_in;
    acc_add   = acc + ACC_W'(c);
    accept    = in_valid && in_ready;
    closing   = (idx == CNT_W'(WINDOW - 1)) || last_in;
    state_nxt = state;
    acc_nxt   = acc;
    idx_nxt   = idx;
    sum_nxt   = sum_out;
    words_nxt = words_out;
    match_nxt = match_out;
    err_nxt   = err_out | (accept && illegal);
    case (state)
      ACCUM: begin
        if (accept) begin
          if (closing) begin
            sum_nxt   = acc_add;
            words_nxt = idx + 1'b1;
            match_nxt = (acc_add >= threshold);
            acc_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            acc_nxt = acc_add;
            idx_nxt = idx + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      idx       <= '0;
      sum_out   <= '0;
      words_out <= '0;
      match_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      idx       <= idx_nxt;
      sum_out   <= sum_nxt;
      words_out <= words_nxt;
      match_out <= match_nxt;
      err_out   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_popcount_window_acc.sv
// Scoreboard bench for popcount_window_acc: expected window results are queued
// when the closing word is driven and compared when the output handshake fires.
module tb_popcount_window_acc;
  localparam int WINDOW = 8;
  localparam int ACC_W  = 8;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       count_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             last_in = 1'b0;
  logic [ACC_W-1:0] threshold = '0;
  logic [ACC_W-1:0] sum_out;
  logic [CNT_W-1:0] words_out;
  logic             match_out;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             err_out;

  typedef struct {
    int sum;
    int words;
    int match;
  } result_t;

  result_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_acc = 0;
  int m_idx = 0;

  popcount_window_acc #(.WINDOW(WINDOW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .in_valid(in_valid),
    .in_ready(in_ready), .last_in(last_in), .threshold(threshold),
    .sum_out(sum_out), .words_out(words_out), .match_out(match_out),
    .out_valid(out_valid), .out_ready(out_ready), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one word and wait until it is accepted; model the window as it goes.
  task automatic send(input int cnt, input bit last, input int thr);
    int c;
    bit done;
    done = 1'b0;
    count_in  = 5'(cnt);
    last_in   = last;
    threshold = ACC_W'(thr);
    in_valid  = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        c = (cnt > 16) ? 16 : cnt;
        if (m_idx == WINDOW - 1 || last) begin
          exp_q.push_back('{sum: m_acc + c, words: m_idx + 1,
                            match: ((m_acc + c) >= thr) ? 1 : 0});
          m_acc = 0;
          m_idx = 0;
        end else begin
          m_acc += c;
          m_idx++;
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_acc = 0;
    m_idx = 0;
    #1;
    chk("rst_sum", int'(sum_out), 0);
    chk("rst_words", int'(words_out), 0);
    chk("rst_match", int'(match_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err", int'(err_out), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: a handshake at the coming edge retires one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        chk("sum_out", int'(sum_out), e.sum);
        chk("words_out", int'(words_out), e.words);
        chk("match_out", int'(match_out), e.match);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // 1: full window, in_ready low for exactly one cycle after close
    for (int i = 0; i < 8; i++) send(3, 0, 20);
    @(negedge clk);
    chk("t1_in_ready_hold", int'(in_ready), 0);
    chk("t1_out_valid", int'(out_valid), 1);
    @(negedge clk);
    chk("t1_in_ready_back", int'(in_ready), 1);
    chk("t1_out_valid_drop", int'(out_valid), 0);
    @(posedge clk); #1;

    // 2: early close with last_in
    send(16, 0, 22); send(0, 0, 22); send(5, 1, 22);
    drain();

    // last_in on first word; last_in without in_valid ignored
    send(9, 1, 9);
    drain();
    last_in = 1'b1;
    @(posedge clk); #1;
    last_in = 1'b0;
    for (int i = 0; i < 8; i++) send(i, 0, 100);
    drain();

    // 3: backpressure with in_valid held high
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(2, 0, 16);
    count_in = 5'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_in_ready", int'(in_ready), 0);
      chk("t3_out_valid", int'(out_valid), 1);
      chk("t3_sum_stable", int'(sum_out), 16);
      chk("t3_match_stable", int'(match_out), 1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    for (int i = 0; i < 8; i++) send(1, 0, 0);
    drain();

    // 5: reset mid-window
    for (int i = 0; i < 4; i++) send(10, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) send(1, 0, 8);
    drain();

    // 4: illegal count clamps and sets sticky error
    send(31, 0, 0);
    for (int i = 0; i < 7; i++) send(0, 0, 0);
    drain();
    chk("t4_err_set", int'(err_out), 1);
    for (int i = 0; i < 8; i++) send(1, 0, 0);
    drain();
    chk("t4_err_sticky", int'(err_out), 1);
    do_reset();

    // 6: threshold sampled only on the closing accept
    for (int i = 0; i < 7; i++) send(4, 0, 5);
    send(4, 0, 40);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/popcount_window_acc.md
Name: popcount_window_acc

Overview:
Downstream consumer of the 16-bit popcount stage. Accepts one 5-bit popcount per cycle over a valid/ready handshake and sums WINDOW consecutive counts, or fewer if the window is closed early with last_in. Presents the window sum, word count and a threshold-match flag on a held output handshake. The result is the per-window mismatch/match density used by the downstream scoring logic.

Parameters:
WINDOW, 8, number of words per window; legal range 1..15.
ACC_W, 8, width of the sum path; must satisfy 2^ACC_W - 1 >= 16*WINDOW.
CNT_W, 4, width of the word counter; must satisfy 2^CNT_W - 1 >= WINDOW.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
count_in  input  5  popcount of one 16-bit word; legal range 0..16.
in_valid  input  1  count_in and last_in are valid.
in_ready  output  1  block can accept a word this cycle.
last_in  input  1  the accepted word closes the window early.
threshold  input  ACC_W  match threshold, sampled on the closing accept.
sum_out  output  ACC_W  window sum.
words_out  output  CNT_W  number of words in the window (1..WINDOW).
match_out  output  1  asserted when sum_out >= threshold.
out_valid  output  1  result is valid and held.
out_ready  input  1  consumer accepts the result.
err_out  output  1  sticky flag: an illegal count_in (>16) was accepted.

Behaviour:
- Reset (asynchronous, immediate): state=ACCUM, acc=0, idx=0, sum_out=0, words_out=0, match_out=0, out_valid=0, err_out=0, in_ready=1. Reset mid-window discards the partial sum. Reset during HOLD drops out_valid without a handshake.
- Accept condition: in_valid && in_ready.
- in_ready is asserted exactly when state==ACCUM; it is a registered-state decode with no combinational path from in_valid or out_ready.
- ACCUM, non-closing accept (idx != WINDOW-1 and last_in=0):
  - acc <= acc + c, where c = count_in clamped to 16.
  - idx <= idx + 1.
  - Outputs are unchanged.
- ACCUM, closing accept (idx == WINDOW-1 or last_in=1):
  - sum_out <= acc + c; words_out <= idx + 1.
  - match_out <= (acc + c >= threshold), unsigned compare.
  - out_valid <= 1; acc <= 0; idx <= 0; state <= HOLD.
- Latency: a result is visible on the cycle after the closing accept.
- HOLD:
  - in_ready=0.
  - sum_out, words_out and match_out stay stable while out_valid=1.
  - When out_valid && out_ready: out_valid <= 0 and state <= ACCUM, so in_ready=1 on the next cycle.
  - Peak throughput is WINDOW words per WINDOW+1 cycles.
- Clamp: if count_in > 16 on an accept, 16 is added and err_out <= 1. err_out clears only on rst.
- last_in on the first word of a window gives words_out=1. last_in with in_valid=0 is ignored.
- WINDOW=1: every accept closes the window.
- Arithmetic: all unsigned. Given the parameter constraints the sum cannot overflow, so no wrap handling is required.
- threshold is used only on the closing-accept cycle. Changes on any other cycle have no effect.
- out_ready while out_valid=0 has no effect.
- Data on count_in and last_in is ignored when no accept occurs.

Test Plan:
1. Reset, then 8 back-to-back accepts of count_in=3, threshold=20, out_ready=1 -> one cycle after the 8th accept: out_valid=1, sum_out=24, words_out=8, match_out=1; in_ready=0 for one cycle, then 1.
2. Accept counts 16,0,5 with last_in=1 on the third, threshold=22 -> sum_out=21, words_out=3, match_out=0.
3. Backpressure: close a window (8×2, threshold=16), hold out_ready=0 for 5 cycles while driving in_valid=1 -> sum_out=16 and match_out=1 stay stable, in_ready=0 throughout, no words are consumed; out_ready=1 releases it and the next window starts from acc=0.
4. Illegal input: accept count_in=31 then 7×0 -> sum_out=16 and err_out=1; err_out persists through the next window; rst clears it.
5. Reset mid-operation: assert rst after 4 accepts of count 10 -> all outputs go to 0 immediately; the next 8×1 window yields sum_out=8 and words_out=8.
6. Threshold sampling: drive threshold=5 during accumulation and change it to 40 on the closing-accept cycle of 8×4 -> match_out=0 (32 < 40).
